// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer
// Command sequencer in front of the operand stack. It takes one stack-machine
// command at a time on a valid/ready handshake and turns it into the stack
// pop/compute/push sequence. It reports each result and flags underflow and
// overflow with a sticky error bit.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op, cmd_imm      opcode (PUSHI POP ADD SUB AND NOT DUP NOP) and immediate
//   stk_push/pop/tos     one-cycle strobes to the stack
//   stk_din              push data to the stack (zero when not pushing)
//   stk_dout             combinational top-of-stack from the stack
//   result/result_valid  last computed or popped value, one-cycle valid pulse
//   count                tracked stack occupancy
//   err                  sticky underflow/overflow flag
module stack_op_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_tos,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_PUSHI = 3'd0,
        OP_POP   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_NOT   = 3'd5,
        OP_DUP   = 3'd6,
        OP_NOP   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_A  = 3'd1,
        POP_B  = 3'd2,
        PUSH_R = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    state_e           r_state,  w_state_next;
    op_e              r_op,     w_op_next;
    logic [WIDTH-1:0] r_a,      w_a_next;
    logic [WIDTH-1:0] r_r,      w_r_next;
    logic [CNT_W-1:0] r_count,  w_count_next;
    logic             r_err,    w_err_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic             r_result_valid, w_result_valid_next;
    logic             r_stk_push, w_stk_push_next;
    logic             r_stk_pop,  w_stk_pop_next;
    logic             r_stk_tos,  w_stk_tos_next;
    logic [WIDTH-1:0] r_stk_din,  w_stk_din_next;
    logic             r_cmd_ready;
    logic [WIDTH-1:0] w_alu;
    op_e              w_cmd_op;

    assign w_cmd_op = op_e'(cmd_op);

    // Binary op result: B is the value exposed after the first pop (stk_dout in POP_B)
    always_comb begin
        case (r_op)
            OP_ADD:  w_alu = stk_dout + r_a;
            OP_SUB:  w_alu = stk_dout - r_a;
            default: w_alu = stk_dout & r_a;
        endcase
    end

    // Next-state and next-output logic; strobes are decoded one cycle early so
    // they come out of flops aligned with the state that owns them.
    always_comb begin
        w_state_next        = r_state;
        w_op_next           = r_op;
        w_a_next            = r_a;
        w_r_next            = r_r;
        w_count_next        = r_count;
        w_err_next          = r_err;
        w_result_next       = r_result;
        w_result_valid_next = 1'b0;
        w_stk_push_next     = 1'b0;
        w_stk_pop_next      = 1'b0;
        w_stk_tos_next      = 1'b0;
        w_stk_din_next      = '0;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_op_next = w_cmd_op;
                    case (w_cmd_op)
                        OP_PUSHI: begin
                            if (r_count == CNT_FULL) begin
                                w_err_next = 1'b1;
                            end else begin
                                w_state_next    = PUSH_R;
                                w_r_next        = cmd_imm;
                                w_stk_push_next = 1'b1;
                                w_stk_din_next  = cmd_imm;
                            end
                        end
                        OP_POP, OP_NOT: begin
                            if (r_count < CNT_ONE) begin
                                w_err_next = 1'b1;
                            end else begin
                                w_state_next   = POP_A;
                                w_stk_pop_next = 1'b1;
                                w_stk_tos_next = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            if (r_count < CNT_TWO) begin
                                w_err_next = 1'b1;
                            end else begin
                                w_state_next   = POP_A;
                                w_stk_pop_next = 1'b1;
                                w_stk_tos_next = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            if ((r_count < CNT_ONE) || (r_count == CNT_FULL)) begin
                                w_err_next = 1'b1;
                            end else begin
                                // POP_B doubles as a read-only peek for DUP
                                w_state_next   = POP_B;
                                w_stk_tos_next = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            POP_A: begin
                w_a_next     = stk_dout;
                w_count_next = r_count - CNT_ONE;
                case (r_op)
                    OP_POP: begin
                        w_state_next        = DONE;
                        w_result_next       = stk_dout;
                        w_result_valid_next = 1'b1;
                    end
                    OP_NOT: begin
                        w_state_next    = PUSH_R;
                        w_r_next        = ~stk_dout;
                        w_stk_push_next = 1'b1;
                        w_stk_din_next  = ~stk_dout;
                    end
                    default: begin
                        w_state_next   = POP_B;
                        w_stk_pop_next = 1'b1;
                        w_stk_tos_next = 1'b1;
                    end
                endcase
            end

            POP_B: begin
                w_state_next    = PUSH_R;
                w_stk_push_next = 1'b1;
                if (r_op == OP_DUP) begin
                    w_a_next       = stk_dout;
                    w_r_next       = stk_dout;
                    w_stk_din_next = stk_dout;
                end else begin
                    w_count_next   = r_count - CNT_ONE;
                    w_r_next       = w_alu;
                    w_stk_din_next = w_alu;
                end
            end

            PUSH_R: begin
                w_count_next        = r_count + CNT_ONE;
                w_state_next        = DONE;
                w_result_next       = r_r;
                w_result_valid_next = 1'b1;
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_op           <= OP_NOP;
            r_a            <= '0;
            r_r            <= '0;
            r_count        <= '0;
            r_err          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_stk_push     <= 1'b0;
            r_stk_pop      <= 1'b0;
            r_stk_tos      <= 1'b0;
            r_stk_din      <= '0;
            r_cmd_ready    <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_op           <= w_op_next;
            r_a            <= w_a_next;
            r_r            <= w_r_next;
            r_count        <= w_count_next;
            r_err          <= w_err_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            r_stk_push     <= w_stk_push_next;
            r_stk_pop      <= w_stk_pop_next;
            r_stk_tos      <= w_stk_tos_next;
            r_stk_din      <= w_stk_din_next;
            r_cmd_ready    <= (w_state_next == IDLE);
        end
    end

    // Strobes are masked by rst so an aborted sequence never touches the stack
    // in the reset cycle.
    assign stk_push     = r_stk_push & ~rst;
    assign stk_pop      = r_stk_pop  & ~rst;
    assign stk_tos      = r_stk_tos  & ~rst;
    assign stk_din      = rst ? '0 : r_stk_din;
    assign cmd_ready    = r_cmd_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign count        = r_count;
    assign err          = r_err;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Testbench for stack_op_sequencer: behavioural operand stack, strobe monitor,
// table of directed commands and hand-written overflow / reset-abort sequences.
module tb_stack_op_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [2:0] PUSHI = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           AND_ = 3'd4, NOT_ = 3'd5, DUP = 3'd6, NOP = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm;
    logic             stk_push, stk_pop, stk_tos;
    logic [WIDTH-1:0] stk_din;
    logic [WIDTH-1:0] stk_dout;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [CNT_W-1:0] count;
    logic             err;

    stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
        .stk_din(stk_din), .stk_dout(stk_dout),
        .result(result), .result_valid(result_valid),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural 32-entry stack
    logic [WIDTH-1:0] mem [0:31];
    logic [5:0]       sp = 6'd0;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 6'd0;
        end else if (stk_push && sp < 6'd32) begin
            mem[5'(sp)] <= stk_din;
            sp <= sp + 6'd1;
        end else if (stk_pop && sp > 6'd0) begin
            sp <= sp - 6'd1;
        end
    end

    always_comb stk_dout = (sp > 6'd0) ? mem[5'(sp - 6'd1)] : 8'h00;

    // Strobe monitor
    int               n_push, n_pop, n_tos;
    logic [WIDTH-1:0] last_din;
    logic             prev_push = 1'b0;
    logic             mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((stk_push && stk_pop) || (!stk_push && stk_din != 8'h00) ||
                (stk_push && prev_push) || (stk_pop && !stk_tos) ||
                (stk_push && sp == 6'd32) || (stk_pop && sp == 6'd0) ||
                (count != sp)) begin
                errors++;
                $display("FAIL monitor t=%0t: push=%0b pop=%0b tos=%0b din=%02h count=%0d required stack_depth=%0d",
                         $time, stk_push, stk_pop, stk_tos, stk_din, count, sp);
            end
            if (stk_push) begin
                n_push++;
                last_din = stk_din;
            end
            if (stk_pop) n_pop++;
            if (stk_tos) n_tos++;
            prev_push = stk_push;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Issue one command; lat is the cycle of result_valid after accept (0 if none)
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] imm,
                           output int lat, output logic [7:0] res);
        int k;
        k = 0;
        while (!cmd_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        n_push = 0; n_pop = 0; n_tos = 0; last_din = 8'h00;
        cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = NOP; cmd_imm = 8'h00;
        lat = 0; res = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            if (result_valid) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] imm;
        int         lat;
        logic [7:0] res;
        int         cnt;
        logic       err;
        int         np;
        int         npop;
        int         ntos;
        logic [7:0] din;
    } vec_t;

    vec_t vq[$];

    int         lat;
    logic [7:0] res;

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        op    imm    lat res    cnt err np pop tos din
        vq.push_back('{PUSHI, 8'h05, 2, 8'h05, 1, 1'b0, 1, 0, 0, 8'h05});
        vq.push_back('{PUSHI, 8'h03, 2, 8'h03, 2, 1'b0, 1, 0, 0, 8'h03});
        vq.push_back('{SUB,   8'h00, 4, 8'h02, 1, 1'b0, 1, 2, 2, 8'h02});
        vq.push_back('{POP,   8'h00, 2, 8'h02, 0, 1'b0, 0, 1, 1, 8'h00});
        vq.push_back('{PUSHI, 8'hFF, 2, 8'hFF, 1, 1'b0, 1, 0, 0, 8'hFF});
        vq.push_back('{PUSHI, 8'h02, 2, 8'h02, 2, 1'b0, 1, 0, 0, 8'h02});
        vq.push_back('{ADD,   8'h00, 4, 8'h01, 1, 1'b0, 1, 2, 2, 8'h01});
        vq.push_back('{POP,   8'h00, 2, 8'h01, 0, 1'b0, 0, 1, 1, 8'h00});
        vq.push_back('{PUSHI, 8'hF0, 2, 8'hF0, 1, 1'b0, 1, 0, 0, 8'hF0});
        vq.push_back('{PUSHI, 8'h3C, 2, 8'h3C, 2, 1'b0, 1, 0, 0, 8'h3C});
        vq.push_back('{AND_,  8'h00, 4, 8'h30, 1, 1'b0, 1, 2, 2, 8'h30});
        vq.push_back('{POP,   8'h00, 2, 8'h30, 0, 1'b0, 0, 1, 1, 8'h00});
        vq.push_back('{PUSHI, 8'h0F, 2, 8'h0F, 1, 1'b0, 1, 0, 0, 8'h0F});
        vq.push_back('{NOT_,  8'h00, 3, 8'hF0, 1, 1'b0, 1, 1, 1, 8'hF0});
        vq.push_back('{DUP,   8'h00, 3, 8'hF0, 2, 1'b0, 1, 0, 1, 8'hF0});
        vq.push_back('{POP,   8'h00, 2, 8'hF0, 1, 1'b0, 0, 1, 1, 8'h00});
        vq.push_back('{ADD,   8'h00, 0, 8'h00, 1, 1'b1, 0, 0, 0, 8'h00});
        vq.push_back('{PUSHI, 8'h07, 2, 8'h07, 2, 1'b1, 1, 0, 0, 8'h07});
        vq.push_back('{NOP,   8'h00, 0, 8'h00, 2, 1'b1, 0, 0, 0, 8'h00});
        vq.push_back('{SUB,   8'h00, 4, 8'hE9, 1, 1'b1, 1, 2, 2, 8'hE9});
        vq.push_back('{POP,   8'h00, 2, 8'hE9, 0, 1'b1, 0, 1, 1, 8'h00});
        vq.push_back('{POP,   8'h00, 0, 8'h00, 0, 1'b1, 0, 0, 0, 8'h00});
        vq.push_back('{NOT_,  8'h00, 0, 8'h00, 0, 1'b1, 0, 0, 0, 8'h00});
        vq.push_back('{DUP,   8'h00, 0, 8'h00, 0, 1'b1, 0, 0, 0, 8'h00});
        vq.push_back('{SUB,   8'h00, 0, 8'h00, 0, 1'b1, 0, 0, 0, 8'h00});

        cmd_op = NOP; cmd_imm = 8'h00;
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_strobes", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
        chk("rst_din", 32'(stk_din), 32'd0);
        mon_en = 1'b1;

        foreach (vq[i]) begin
            run_cmd(vq[i].op, vq[i].imm, lat, res);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vq[i].lat));
            if (vq[i].lat != 0) chk($sformatf("v%0d_result", i), 32'(res), 32'(vq[i].res));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].cnt));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vq[i].err));
            chk($sformatf("v%0d_pushes", i), 32'(n_push), 32'(vq[i].np));
            chk($sformatf("v%0d_pops", i), 32'(n_pop), 32'(vq[i].npop));
            chk($sformatf("v%0d_tos", i), 32'(n_tos), 32'(vq[i].ntos));
            chk($sformatf("v%0d_din", i), 32'(last_din), 32'(vq[i].din));
            chk($sformatf("v%0d_rv_pulse", i), 32'(result_valid), 32'd0);
        end

        // Fill the stack, then overflow via DUP and PUSHI
        do_reset();
        for (int i = 0; i < 32; i++) begin
            run_cmd(PUSHI, 8'(i * 3 + 1), lat, res);
        end
        chk("full_count", 32'(count), 32'd32);
        chk("full_err", 32'(err), 32'd0);
        run_cmd(DUP, 8'h00, lat, res);
        chk("ovf_dup_err", 32'(err), 32'd1);
        chk("ovf_dup_count", 32'(count), 32'd32);
        chk("ovf_dup_push", 32'(n_push + n_tos), 32'd0);
        chk("ovf_dup_lat", 32'(lat), 32'd0);
        run_cmd(PUSHI, 8'hAA, lat, res);
        chk("ovf_pushi_count", 32'(count), 32'd32);
        chk("ovf_pushi_push", 32'(n_push), 32'd0);
        run_cmd(POP, 8'h00, lat, res);
        chk("full_pop_lat", 32'(lat), 32'd2);
        chk("full_pop_result", 32'(res), 32'h5E);
        chk("full_pop_count", 32'(count), 32'd31);

        // Reset in the middle of an ADD (during POP_B) with err already set
        do_reset();
        run_cmd(POP, 8'h00, lat, res);
        chk("abort_pre_err", 32'(err), 32'd1);
        run_cmd(PUSHI, 8'h01, lat, res);
        run_cmd(PUSHI, 8'h02, lat, res);
        cmd_valid = 1'b1; cmd_op = ADD;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = NOP;
        chk("busy_not_ready", 32'(cmd_ready), 32'd0);
        chk("pop_a_strobe", {30'd0, stk_pop, stk_tos}, 32'd3);
        @(posedge clk); #1;
        chk("pop_b_strobe", {30'd0, stk_pop, stk_tos}, 32'd3);
        chk("pop_b_count", 32'(count), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_strobes", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_strobes", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
        chk("abort_rv", 32'(result_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        run_cmd(PUSHI, 8'h11, lat, res);
        chk("post_abort_lat", 32'(lat), 32'd2);
        chk("post_abort_result", 32'(res), 32'h11);
        chk("post_abort_count", 32'(count), 32'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Command sequencer that sits directly upstream of the 8-bit, 32-entry operand stack; it is the only agent driving the stack's push/pop/TOS strobes and data input, and it consumes the stack's top-of-stack output.
- Accepts one stack-machine command at a time over a valid/ready handshake.
- Performs the required pop/compute/push sequence, reports the result, and guards against stack underflow and overflow.

Parameters:
- WIDTH, 8: data width; matches the stack entry width.
- DEPTH, 32: stack capacity in entries; must match the stack instance.
- CNT_W, 6: occupancy counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset; the same net also resets the stack instance.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 PUSHI, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 NOT, 6 DUP, 7 NOP.
- cmd_imm  in  WIDTH  immediate for PUSHI.
- stk_push  out  1  Push strobe to the stack.
- stk_pop  out  1  Pop strobe to the stack.
- stk_tos  out  1  TOS read strobe to the stack; asserted whenever stk_dout is sampled.
- stk_din  out  WIDTH  data to the stack.
- stk_dout  in  WIDTH  current top-of-stack from the stack; combinational, valid when occupancy > 0.
- result  out  WIDTH  last computed or popped value.
- result_valid  out  1  one-cycle pulse when result updates.
- count  out  CNT_W  current stack occupancy.
- err  out  1  sticky error flag.

Behaviour:
- Reset, synchronous: state IDLE; count=0; err=0; result=0; result_valid=0; all stk_* strobes=0; stk_din=0; cmd_ready=1 in the following cycle. Reset in any state aborts the sequence, and no strobe is issued in the reset cycle.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted at a rising edge with cmd_valid & cmd_ready; opcode and immediate are latched at that edge.
  - The upstream must hold the command until it is accepted.
- FSM states: IDLE, POP_A, POP_B, PUSH_R, DONE.
- Error checks at accept, using count:
  - ADD/SUB/AND with count<2 is an underflow.
  - POP/NOT/DUP with count<1 is an underflow.
  - PUSHI/DUP with count==DEPTH is an overflow.
  - On any error: err is set and held until rst; the command is consumed; no stack strobe is issued; result_valid stays 0; FSM stays in IDLE.
  - Further commands are still processed normally while err=1.
- PUSHI: IDLE->PUSH_R. stk_push=1, stk_din=imm. count+1. Then DONE.
- POP: IDLE->POP_A.
  - In POP_A: stk_tos=1, stk_pop=1, A<=stk_dout, count-1.
  - Then DONE with result=A.
- Binary ops (ADD/SUB/AND): IDLE->POP_A->POP_B->PUSH_R->DONE.
  - POP_A: stk_tos=1, stk_pop=1, A<=stk_dout.
  - POP_B: stk_tos=1, stk_pop=1, B<=stk_dout; this is the value exposed after the first pop.
  - PUSH_R: stk_push=1, stk_din=R. R is B+A, B-A or B&A, truncated modulo 2^WIDTH with no carry or borrow output.
  - Net count change is -1.
- NOT: POP_A, then PUSH_R with R=~A. Net count change is 0.
- DUP: IDLE->POP_B, reused as a read-only state: stk_tos=1, A<=stk_dout, no pop. Then PUSH_R with R=A. count+1.
- NOP: accepted; no strobes; no result_valid; stays in IDLE.
- DONE: result<=R (or A for POP), result_valid=1 for exactly this cycle, then IDLE.
- Latency from the accept edge to the result_valid cycle:
  - PUSHI: 2 cycles. POP: 2. DUP: 3. NOT: 3. Binary: 4.
  - Throughput is one command per latency plus one IDLE cycle.
- Stack strobe rules:
  - stk_push and stk_pop are never both 1 in the same cycle.
  - Each strobe is high for exactly one cycle per action.
  - stk_din=0 whenever stk_push=0.
- count updates on the same edge as the corresponding stack strobe. It never exceeds DEPTH and never wraps below 0.

Test Plan:
- rst, then PUSHI 0x05, then PUSHI 0x03 -> each result_valid 2 cycles after accept; count=2; stk_push pulses carry 0x05 then 0x03.
- From {0x05,0x03}, SUB -> two stk_pop pulses, then stk_push with stk_din=0x02; result=0x02 after 4 cycles; count=1.
- PUSHI 0xFF, PUSHI 0x02, ADD -> result=0x01 (wrap); AND of 0xF0 and 0x3C -> 0x30; NOT of 0x0F -> 0xF0.
- From count=1, issue ADD -> err=1; no stk_* strobe; count stays 1. Next PUSHI 0x07 still succeeds, with err remaining 1.
- Issue 32 PUSHI, then DUP -> err=1; count=32; no push strobe. Then POP -> result equals the last pushed value; count=31.
- Assert rst during POP_B of an ADD -> the following cycle shows count=0, err=0, cmd_ready=1, all strobes 0.
